// File: rtl/count_sequencer.sv
// rtl/count_sequencer.sv - run/pause/stop sequencer for a prescaled up/down display counter
//
// Purpose:
//   Divides clk into a step tick of TICK_DIV cycles and walks an up/down counter
//   between 0 and limit under start/stop/clear/load commands. The counter stops in
//   DONE at the terminal value. With COUNT_SEQ_AUTO_RELOAD_EN defined it instead
//   wraps (up -> 0, down -> limit), stays in RUN and pulses done for that step.
//
// Parameters:
//   TICK_DIV  clk cycles per count step (>=1)
//   CNT_W     counter width
//
// Ports:
//   clk       rising-edge clock
//   Reset     synchronous reset, active-high
//   start     1-cycle command: IDLE/PAUSE -> RUN
//   stop      1-cycle command: RUN -> PAUSE
//   clear     1-cycle command: count=0, prescaler=0, -> IDLE
//   load      1-cycle command: count=min(load_val,limit); DONE -> IDLE
//   load_val  value for load
//   up_dn     1 = count up toward limit, 0 = count down toward 0
//   limit     terminal value (up) / reload value (down wrap)
//   count     current count, registered
//   tick      1-cycle pulse, high in the cycle count shows a stepped value
//   state     IDLE=00 RUN=01 PAUSE=10 DONE=11
//   done      terminal-count flag
//
// Configuration macro: COUNT_SEQ_AUTO_RELOAD_EN

module count_sequencer #(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             up_dn,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             tick,
    output logic [1:0]       state,
    output logic             done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             tick_q, tick_d;
    logic             done_pulse_q, done_pulse_d;

    logic [CNT_W-1:0] load_cnt;
    logic             step;
    logic             terminal;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        presc_d      = presc_q;
        tick_d       = 1'b0;
        done_pulse_d = 1'b0;

        load_cnt = (load_val > limit) ? limit : load_val;
        // A stop in the same cycle freezes the prescaler so resume keeps the phase.
        step     = (state_q == ST_RUN) && !clear && !stop && (presc_q == PRESC_MAX);
        terminal = up_dn ? (count_q >= limit) : (count_q == '0);

        if (clear) begin
            state_d = ST_IDLE;
            count_d = '0;
            presc_d = '0;
        end else begin
            if ((state_q == ST_RUN) && !stop) begin
                presc_d = step ? '0 : presc_q + 1'b1;
            end

            if (load) begin
                // load owns the count this cycle; a coinciding step is dropped.
                count_d = load_cnt;
                if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end else if (stop && (state_q == ST_RUN)) begin
                state_d = ST_PAUSE;
            end else if (start && ((state_q == ST_IDLE) || (state_q == ST_PAUSE))) begin
                state_d = ST_RUN;
                // Fresh run starts a full tick period; resume from PAUSE keeps phase.
                if (state_q == ST_IDLE) begin
                    presc_d = '0;
                end
            end else if (step) begin
                if (!terminal) begin
                    count_d = up_dn ? count_q + 1'b1 : count_q - 1'b1;
                    tick_d  = 1'b1;
                end else begin
`ifdef COUNT_SEQ_AUTO_RELOAD_EN
                    count_d      = up_dn ? '0 : limit;
                    tick_d       = 1'b1;
                    done_pulse_d = 1'b1;
`else
                    state_d = ST_DONE;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            presc_q      <= '0;
            tick_q       <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            presc_q      <= presc_d;
            tick_q       <= tick_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    assign count = count_q;
    assign tick  = tick_q;
    assign state = state_q;
    assign done  = (state_q == ST_DONE) | done_pulse_q;

endmodule

// File: tb/tb_count_sequencer.sv
// tb/tb_count_sequencer.sv - scoreboard bench for count_sequencer (TICK_DIV=4, CNT_W=8)
//
// Purpose:
//   Directed command sequences; expected tick counts are queued when a run is
//   started and a monitor pops them whenever the DUT pulses tick. State, done and
//   timing are compared directly by the stimulus thread.
//
// Ports: none (drives every count_sequencer port)
//
// Configuration macro: COUNT_SEQ_AUTO_RELOAD_EN selects the auto-reload sequence.

module tb_count_sequencer;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic       up_dn = 1'b1;
    logic [7:0] limit = 8'd0;
    logic [7:0] count;
    logic       tick;
    logic [1:0] state;
    logic       done;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    count_sequencer #(.TICK_DIV(4), .CNT_W(8)) dut (
        .clk      (clk),
        .Reset    (Reset),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .up_dn    (up_dn),
        .limit    (limit),
        .count    (count),
        .tick     (tick),
        .state    (state),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns the number of edges until tick is seen; 100 marks a timeout.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (!tick && n < 100);
    endtask

    // Scoreboard monitor: every tick must match the next queued count.
    always @(negedge clk) begin
        if (tick) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tick_unexpected count=%0d expected=no_tick", count);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(count) != e) begin
                    errors++;
                    $display("FAIL tick_count actual=%0d expected=%0d", count, e);
                end
            end
        end
    end

    initial begin
        int n;

        // 1. Reset with commands asserted: all ignored.
        start = 1'b1; load = 1'b1; load_val = 8'd7;
        cyc(2);
        check("rst_count", count, 0);
        check("rst_state", state, 0);
        check("rst_tick", tick, 0);
        check("rst_done", done, 0);
        Reset = 1'b0; start = 1'b0; load = 1'b0;
        cyc(1);
        check("post_rst_state", state, 0);
        check("post_rst_count", count, 0);

`ifdef COUNT_SEQ_AUTO_RELOAD_EN
        // 6. Auto-reload: 1,2,0,1 with a done pulse on the wrap, staying in RUN.
        up_dn = 1'b1; limit = 8'd2;
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(0); exp_q.push_back(1);
        start = 1'b1; cyc(1); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_tick(n);
            check("ar_tick_period", n, 4);
            check("ar_state", state, 1);
            check("ar_done", done, (i == 2) ? 1 : 0);
        end
`else
        // 2. Count up to limit=3, then terminal step enters DONE without tick.
        up_dn = 1'b1; limit = 8'd3;
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        start = 1'b1; cyc(1); start = 1'b0;
        check("run_state", state, 1);
        for (int i = 0; i < 3; i++) begin
            wait_tick(n);
            check("up_tick_period", n, 4);
        end
        cyc(4);
        check("up_done_state", state, 3);
        check("up_done_flag", done, 1);
        check("up_done_count", count, 3);
        start = 1'b1; cyc(1); start = 1'b0;
        check("done_start_ignored", state, 3);

        // 4. Load clamps and leaves DONE; count down 2 -> 1 -> 0 -> DONE.
        load_val = 8'd9; load = 1'b1; cyc(1); load = 1'b0;
        check("load_clamp_count", count, 3);
        check("load_clamp_state", state, 0);
        check("load_clears_done", done, 0);
        load_val = 8'd2; up_dn = 1'b0; load = 1'b1; cyc(1); load = 1'b0;
        check("load_count", count, 2);
        exp_q.push_back(1); exp_q.push_back(0);
        start = 1'b1; cyc(1); start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wait_tick(n);
            check("dn_tick_period", n, 4);
        end
        cyc(4);
        check("dn_done_state", state, 3);
        check("dn_done_count", count, 0);
        check("dn_done_flag", done, 1);

        // 3. Pause two cycles after a tick; resume keeps the prescaler phase.
        clear = 1'b1; cyc(1); clear = 1'b0;
        check("clear_state", state, 0);
        up_dn = 1'b1; limit = 8'd20;
        exp_q.push_back(1); exp_q.push_back(2);
        start = 1'b1; cyc(1); start = 1'b0;
        wait_tick(n);
        check("pause_first_tick", n, 4);
        cyc(2);
        stop = 1'b1; cyc(1); stop = 1'b0;
        check("pause_state", state, 2);
        cyc(10);
        check("pause_hold_count", count, 1);
        check("pause_hold_state", state, 2);
        start = 1'b1; cyc(1); start = 1'b0;
        check("resume_state", state, 1);
        wait_tick(n);
        check("resume_tick_delay", n, 2);

        // 5. Load mid-RUN, clear+start, then start+stop.
        load_val = 8'd5; load = 1'b1; cyc(1); load = 1'b0;
        check("run_load_count", count, 5);
        check("run_load_state", state, 1);
        clear = 1'b1; start = 1'b1; cyc(1); clear = 1'b0; start = 1'b0;
        check("clear_start_state", state, 0);
        check("clear_start_count", count, 0);
        start = 1'b1; cyc(1); start = 1'b0;
        check("restart_state", state, 1);
        start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
        check("start_stop_state", state, 2);
`endif

        cyc(2);
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
